// File: rtl/whack_round_scheduler_pkg.sv
// Shared definitions for the whack-a-mole round scheduler and the score datapath:
// state encodings, LFSR seed/taps and small helpers.
package whack_round_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GAP  = 3'd1,
        S_UP   = 3'd2,
        S_HIT  = 3'd3,
        S_MISS = 3'd4,
        S_OVER = 3'd5
    } state_t;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Tap positions (zero based) for the x^16 + x^14 + x^13 + x^11 + 1 polynomial.
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;

    function automatic logic lfsrFeedback(input logic [15:0] q);
        return q[LFSR_TAP_A] ^ q[LFSR_TAP_B] ^ q[LFSR_TAP_C] ^ q[LFSR_TAP_D];
    endfunction

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/whack_round_scheduler_if.sv
// Handshake bundle between the button front end, the round scheduler and the
// display/score datapath. The scheduler sits on the slave side.
interface whack_round_scheduler_if #(
    parameter int NUM_MOLES = 4,
    parameter int SCORE_W   = 8
);
    logic                 start;
    logic [NUM_MOLES-1:0] btn;
    logic [NUM_MOLES-1:0] mole_onehot;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic [SCORE_W-1:0]   score;
    logic [3:0]           misses;
    logic                 game_over;
    logic                 busy;

    modport master (
        output start, btn,
        input  mole_onehot, hit_pulse, miss_pulse, score, misses, game_over, busy
    );

    modport slave (
        input  start, btn,
        output mole_onehot, hit_pulse, miss_pulse, score, misses, game_over, busy
    );
endinterface

// File: rtl/whack_round_scheduler_lfsr.sv
// 16-bit Fibonacci LFSR used to pick the next mole. Free-running every cycle.
module whack_lfsr16
    import whack_round_scheduler_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        Reset,
    output logic [15:0] q
);
    logic [15:0] r_q;

    // Shift left and insert the tap feedback; the seed must be nonzero.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_q <= SEED;
        end else begin
            r_q <= {r_q[14:0], lfsrFeedback(r_q)};
        end
    end

    assign q = r_q;
endmodule

// File: rtl/whack_round_scheduler.sv
// Round sequencer for the whack-a-mole game: gap, pop a mole, judge the press,
// keep score and misses, and shrink the up-window after every hit.
module whack_round_scheduler
    import whack_round_scheduler_pkg::*;
#(
    parameter int          NUM_MOLES  = 4,
    parameter int          GAP_CYCLES = 1000,
    parameter int          UP_INIT    = 4000,
    parameter int          UP_STEP    = 200,
    parameter int          UP_MIN     = 1000,
    parameter int          MAX_MISSES = 3,
    parameter int          SCORE_W    = 8,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic                    clk,
    input  logic                    Reset,
    whack_round_scheduler_if.slave  bus
);
    // The timer also holds up_len itself, so it is sized for the largest value, not its decrement.
    localparam int TIMER_MAX = maxInt(GAP_CYCLES, UP_INIT);
    localparam int TW        = $clog2(TIMER_MAX + 1);
    localparam int IDXW      = $clog2(NUM_MOLES);

    state_t                r_state;
    state_t                w_nextState;
    logic [TW-1:0]         r_timer;
    logic [TW-1:0]         r_upLen;
    logic [IDXW-1:0]       r_prevIdx;
    logic [NUM_MOLES-1:0]  r_btnQ;
    logic [SCORE_W-1:0]    r_score;
    logic [3:0]            r_misses;

    logic [15:0]           w_lfsr;
    logic                  w_unusedLfsrHi;
    logic [NUM_MOLES-1:0]  w_edge;
    logic                  w_timerDone;
    logic                  w_startGame;
    logic [IDXW-1:0]       w_candIdx;
    logic [IDXW-1:0]       w_newIdx;

    whack_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .Reset (Reset),
        .q     (w_lfsr)
    );

    assign w_unusedLfsrHi = ^w_lfsr[15:8];
    assign w_edge         = bus.btn & ~r_btnQ;
    assign w_timerDone    = (r_timer == '0);
    assign w_startGame    = bus.start && ((r_state == S_IDLE) || (r_state == S_OVER));

    // Pick the next mole from the LFSR, stepping past the previous one so rounds never repeat.
    always_comb begin
        w_candIdx = IDXW'(w_lfsr[7:0] % 8'(NUM_MOLES));
        w_newIdx  = w_candIdx;
        if (w_candIdx == r_prevIdx) begin
            w_newIdx = (w_candIdx == IDXW'(NUM_MOLES - 1)) ? '0 : w_candIdx + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; in UP a correct edge beats a wrong edge, which beats timeout.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_nextState = S_GAP;
            S_GAP:  if (w_timerDone) w_nextState = S_UP;
            S_UP: begin
                if (w_edge[r_prevIdx]) begin
                    w_nextState = S_HIT;
                end else if (|w_edge) begin
                    w_nextState = S_MISS;
                end else if (w_timerDone) begin
                    w_nextState = S_MISS;
                end
            end
            S_HIT:  w_nextState = S_GAP;
            S_MISS: w_nextState = (r_misses == 4'(MAX_MISSES)) ? S_OVER : S_GAP;
            S_OVER: if (bus.start) w_nextState = S_GAP;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Timer, up-window, mole index, button history and score counters.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_timer   <= '0;
            r_upLen   <= TW'(UP_INIT);
            r_prevIdx <= '0;
            r_btnQ    <= '1;
            r_score   <= '0;
            r_misses  <= '0;
        end else begin
            r_btnQ <= bus.btn;

            if (w_nextState != r_state) begin
                case (w_nextState)
                    S_GAP:   r_timer <= TW'(GAP_CYCLES - 1);
                    S_UP:    r_timer <= r_upLen - 1'b1;
                    default: r_timer <= '0;
                endcase
            end else if (!w_timerDone) begin
                r_timer <= r_timer - 1'b1;
            end

            if (r_state == S_GAP && w_timerDone) begin
                r_prevIdx <= w_newIdx;
            end

            if (w_startGame) begin
                r_score  <= '0;
                r_misses <= '0;
                r_upLen  <= TW'(UP_INIT);
            end else if (r_state == S_UP && w_nextState == S_HIT) begin
                if (r_score != '1) begin
                    r_score <= r_score + 1'b1;
                end
                if (32'(r_upLen) >= 32'(UP_MIN + UP_STEP)) begin
                    r_upLen <= r_upLen - TW'(UP_STEP);
                end else begin
                    r_upLen <= TW'(UP_MIN);
                end
            end else if (r_state == S_UP && w_nextState == S_MISS) begin
                r_misses <= r_misses + 1'b1;
            end
        end
    end

    // Outputs decoded from registered state so pulses line up with the HIT/MISS cycle.
    always_comb begin
        bus.mole_onehot = '0;
        if (r_state == S_UP) begin
            bus.mole_onehot = NUM_MOLES'(1) << r_prevIdx;
        end
        bus.hit_pulse  = (r_state == S_HIT);
        bus.miss_pulse = (r_state == S_MISS);
        bus.game_over  = (r_state == S_OVER);
        bus.busy       = (r_state == S_GAP) || (r_state == S_UP) ||
                         (r_state == S_HIT) || (r_state == S_MISS);
        bus.score      = r_score;
        bus.misses     = r_misses;
    end
endmodule
